// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite row renderer.
// Holds the image/row-buffer sizing constants, the FSM state type, the
// sprite geometry record and the geometry validity check used when a
// sprite is latched.
package sprite_pkg;

  localparam int MAX_W       = 64;
  localparam int BPP         = 4;
  localparam int SPRITE_BITS = 4500;
  localparam int MAX_PIXELS  = 1125;
  localparam int COL_W       = $clog2(MAX_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] xstart;
    logic [9:0] ystart;
    logic [9:0] xdim;
    logic [9:0] ydim;
  } geom_t;

  // A sprite is usable only if it is non-empty, fits the row buffer and
  // fits inside the packed image.
  function automatic logic geom_ok(geom_t g);
    logic [19:0] area;
    area = 20'(g.xdim) * 20'(g.ydim);
    return (g.xdim != 10'd0) && (g.ydim != 10'd0) &&
           (g.xdim <= 10'(MAX_W)) && (area <= 20'(MAX_PIXELS));
  endfunction

endpackage

// File: rtl/sprite_row_renderer_if.sv
// Bundle of the sprite row renderer's loader, video-timing and pixel
// signals.
//   loader side : readDone, spriteData, xstart, ystart, xdim, ydim
//   video side  : line_start, next_line, DrawX
//   results     : pixel_idx, pixel_opaque, loaded, load_err, busy
// master = the environment driving loader/timing; slave = the renderer.
interface sprite_row_renderer_if;
  import sprite_pkg::*;

  logic                   readDone;
  logic [SPRITE_BITS-1:0] spriteData;
  logic [9:0]             xstart;
  logic [9:0]             ystart;
  logic [9:0]             xdim;
  logic [9:0]             ydim;
  logic                   line_start;
  logic [9:0]             next_line;
  logic [9:0]             DrawX;
  logic [BPP-1:0]         pixel_idx;
  logic                   pixel_opaque;
  logic                   loaded;
  logic                   load_err;
  logic                   busy;

  modport master (
    output readDone, spriteData, xstart, ystart, xdim, ydim,
    output line_start, next_line, DrawX,
    input  pixel_idx, pixel_opaque, loaded, load_err, busy
  );

  modport slave (
    input  readDone, spriteData, xstart, ystart, xdim, ydim,
    input  line_start, next_line, DrawX,
    output pixel_idx, pixel_opaque, loaded, load_err, busy
  );

endinterface

// File: rtl/sprite_row_buf.sv
// Ping-pong row buffer: two MAX_W x BPP banks, one displayed (front) and
// one being filled (back), each with a valid bit.
//   Clk, Reset      : clock, synchronous active-high reset
//   swap            : exchange front/back; the new back is invalidated
//   wr_en/addr/data : write port into the back bank
//   set_back_valid  : mark the back bank as completely filled
//   rd_hit, rd_addr : read request into the front bank
//   rd_data         : registered read data, 0 on miss or invalid front
module sprite_row_buf
  import sprite_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             swap,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [BPP-1:0]   wr_data,
  input  logic             set_back_valid,
  input  logic             rd_hit,
  input  logic [COL_W-1:0] rd_addr,
  output logic [BPP-1:0]   rd_data
);

  logic           front_sel_q, front_sel_d;
  logic           back_sel;
  logic [1:0]     valid_q, valid_d;
  logic [BPP-1:0] bank_q [2][MAX_W];
  logic [BPP-1:0] bank_d [2][MAX_W];
  logic [BPP-1:0] rd_data_q, rd_data_d;

  assign back_sel = ~front_sel_q;

  always_comb begin
    front_sel_d = front_sel_q;
    valid_d     = valid_q;
    bank_d      = bank_q;
    rd_data_d   = '0;
    if (wr_en) begin
      bank_d[back_sel][wr_addr] = wr_data;
    end
    if (swap) begin
      // Old front becomes the new back and must be refilled before use.
      front_sel_d             = back_sel;
      valid_d[front_sel_q]    = 1'b0;
    end else if (set_back_valid) begin
      valid_d[back_sel] = 1'b1;
    end
    if (rd_hit && valid_q[front_sel_q]) begin
      rd_data_d = bank_q[front_sel_q][rd_addr];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      front_sel_q <= 1'b0;
      valid_q     <= '0;
      rd_data_q   <= '0;
    end else begin
      front_sel_q <= front_sel_d;
      valid_q     <= valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge Clk) begin
    bank_q <= bank_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_row_renderer.sv
// Sprite row renderer: latches a sprite from the SRAM loader, pre-fetches
// one sprite row per scanline into a ping-pong buffer and returns the
// palette index for the current DrawX one cycle later.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : loader inputs, line timing, DrawX and pixel/status outputs
//
// state | meaning
// IDLE  | no sprite latched; line_start ignored
// WAIT  | sprite latched, waiting for the next line_start
// FILL  | copying one sprite row into the back bank, one pixel per cycle
module sprite_row_renderer
  import sprite_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  sprite_row_renderer_if.slave  bus
);

  state_t                 state_q, state_d;
  logic [SPRITE_BITS-1:0] sprite_q, sprite_d;
  logic [SPRITE_BITS-1:0] pend_data_q, pend_data_d;
  geom_t                  geom_q, geom_d;
  geom_t                  pend_geom_q, pend_geom_d;
  logic                   pend_q, pend_d;
  logic                   loaded_q, loaded_d;
  logic                   load_err_q, load_err_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [10:0]            base_q, base_d;

  geom_t                  in_geom, src_geom;
  logic [SPRITE_BITS-1:0] src_data;
  logic                   fill_lock, apply_now, apply_pend, src_ok, load_ok;
  logic [10:0]            row_off, dx_off, pix;
  logic [12:0]            bit_idx;
  logic                   row_hit, last_col, in_win;
  logic                   swap, wr_en, set_back_valid;
  logic [BPP-1:0]         wr_data, rd_data;

  assign in_geom = {bus.xstart, bus.ystart, bus.xdim, bus.ydim};

  // The shadow image must not change while a row is being copied out of
  // it, nor in the cycle a fill is being set up; loads arriving then are
  // parked and applied once the FSM is back in WAIT.
  assign fill_lock  = (state_q == FILL) || (bus.line_start && state_q == WAIT);
  assign apply_now  = bus.readDone && !fill_lock;
  assign apply_pend = pend_q && !fill_lock && !apply_now;
  assign src_geom   = apply_now ? in_geom : pend_geom_q;
  assign src_data   = apply_now ? bus.spriteData : pend_data_q;
  assign src_ok     = geom_ok(src_geom);
  assign load_ok    = (apply_now || apply_pend) && src_ok;

  // 11-bit signed row offset: negative means the line is above the sprite.
  assign row_off  = {1'b0, bus.next_line} - {1'b0, geom_q.ystart};
  assign row_hit  = !row_off[10] && (row_off[9:0] < geom_q.ydim);
  assign last_col = (10'(col_q) == geom_q.xdim - 10'd1);
  assign pix      = base_q + 11'(col_q);
  assign bit_idx  = 13'(pix) * 13'(BPP);
  assign wr_data  = sprite_q[bit_idx +: BPP];

  // Horizontal window without wrap: the subtraction is only trusted once
  // DrawX >= xstart has been established.
  assign dx_off = {1'b0, bus.DrawX} - {1'b0, geom_q.xstart};
  assign in_win = ({1'b0, bus.DrawX} >= {1'b0, geom_q.xstart}) &&
                  (dx_off < {1'b0, geom_q.xdim});

  always_comb begin
    sprite_d    = sprite_q;
    geom_d      = geom_q;
    loaded_d    = loaded_q;
    load_err_d  = load_err_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_geom_d = pend_geom_q;
    if (bus.readDone && fill_lock) begin
      pend_d      = 1'b1;
      pend_data_d = bus.spriteData;
      pend_geom_d = in_geom;
    end else if (apply_now || apply_pend) begin
      pend_d = 1'b0;
      if (src_ok) begin
        sprite_d   = src_data;
        geom_d     = src_geom;
        loaded_d   = 1'b1;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    base_d         = base_q;
    swap           = 1'b0;
    wr_en          = 1'b0;
    set_back_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_ok) state_d = WAIT;
      end
      WAIT, FILL: begin
        if (bus.line_start) begin
          // A line_start mid-fill abandons the partial row; it is swapped
          // to the front still invalid, so it is never displayed.
          swap  = 1'b1;
          col_d = '0;
          if (row_hit) begin
            base_d  = 11'(row_off[9:0] * geom_q.xdim);
            state_d = FILL;
          end else begin
            state_d = WAIT;
          end
        end else if (state_q == FILL) begin
          wr_en = 1'b1;
          if (last_col) begin
            set_back_valid = 1'b1;
            state_d        = WAIT;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
      pend_q     <= 1'b0;
      col_q      <= '0;
      base_q     <= '0;
      geom_q     <= '0;
    end else begin
      state_q    <= state_d;
      loaded_q   <= loaded_d;
      load_err_q <= load_err_d;
      pend_q     <= pend_d;
      col_q      <= col_d;
      base_q     <= base_d;
      geom_q     <= geom_d;
    end
  end

  always_ff @(posedge Clk) begin
    sprite_q    <= sprite_d;
    pend_data_q <= pend_data_d;
    pend_geom_q <= pend_geom_d;
  end

  sprite_row_buf u_row_buf (
    .Clk            (Clk),
    .Reset          (Reset),
    .swap           (swap),
    .wr_en          (wr_en),
    .wr_addr        (col_q),
    .wr_data        (wr_data),
    .set_back_valid (set_back_valid),
    .rd_hit         (in_win),
    .rd_addr        (dx_off[COL_W-1:0]),
    .rd_data        (rd_data)
  );

  assign bus.pixel_idx    = rd_data;
  assign bus.pixel_opaque = |rd_data;
  assign bus.loaded       = loaded_q;
  assign bus.load_err     = load_err_q;
  assign bus.busy         = (state_q == FILL);

endmodule

// File: tb/tb_sprite_row_renderer.sv
// Self-checking bench for sprite_row_renderer. A small model tracks which
// sprite row sits in the front/back banks; expected pixels are queued as
// DrawX is driven and compared when the registered output appears.
module tb_sprite_row_renderer;
  import sprite_pkg::*;

  logic clk;
  logic rst;
  sprite_row_renderer_if bus();

  sprite_row_renderer dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  // model: latched geometry and front/back bank contents
  bit m_loaded = 0;
  int m_xs, m_ys, m_xd, m_yd, m_seed;
  bit f_valid = 0, b_valid = 0, fill_on = 0;
  int f_row, f_xd, f_seed, b_row, b_xd, b_seed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SPRITE_BITS-1:0] make_sprite(input int seed);
    logic [SPRITE_BITS-1:0] s;
    s = '0;
    for (int p = 0; p < MAX_PIXELS; p++) s[BPP*p +: BPP] = 4'((p + seed) % 16);
    return s;
  endfunction

  function automatic int model_pix(input int x);
    if (!f_valid) return 0;
    if (x < m_xs || x >= m_xs + m_xd) return 0;
    return (f_row * f_xd + (x - m_xs) + f_seed) % 16;
  endfunction

  task automatic drive_load(input int xs, input int ys, input int xd, input int yd,
                            input int seed);
    tick();
    bus.readDone   = 1'b1;
    bus.spriteData = make_sprite(seed);
    bus.xstart     = 10'(xs);
    bus.ystart     = 10'(ys);
    bus.xdim       = 10'(xd);
    bus.ydim       = 10'(yd);
    tick();
    bus.readDone = 1'b0;
  endtask

  task automatic set_model(input int xs, input int ys, input int xd, input int yd,
                           input int seed);
    m_loaded = 1; m_xs = xs; m_ys = ys; m_xd = xd; m_yd = yd; m_seed = seed;
  endtask

  task automatic pulse_line(input int nl);
    int r;
    bit hit;
    tick();
    bus.line_start = 1'b1;
    bus.next_line  = 10'(nl);
    tick();
    bus.line_start = 1'b0;
    hit = 0;
    if (m_loaded) begin
      f_valid = b_valid; f_row = b_row; f_xd = b_xd; f_seed = b_seed;
      r = nl - m_ys;
      if (r >= 0 && r < m_yd) begin
        hit = 1; b_row = r; b_xd = m_xd; b_seed = m_seed;
      end
      b_valid = 0;
    end
    fill_on = hit;
    n_checks++;
    if (bus.busy !== hit)
      $display("FAIL busy_after_line nl=%0d got %0b want %0b", nl, bus.busy, hit);
    else n_pass++;
  endtask

  task automatic finish_fill(input int exp_n);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL fill_timeout busy still high after %0d cycles", n);
    end else begin
      if (exp_n >= 0) begin
        n_checks++;
        if (n !== exp_n) $display("FAIL fill_length got %0d want %0d", n, exp_n);
        else n_pass++;
      end
      if (fill_on) b_valid = 1;
      fill_on = 0;
    end
  endtask

  task automatic scan(input int x0, input int x1);
    int e;
    for (int x = x0; x <= x1 + 1; x++) begin
      tick();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.pixel_idx !== 4'(e))
          $display("FAIL pixel_idx x=%0d got %0d want %0d", x - 1, bus.pixel_idx, e);
        else n_pass++;
        n_checks++;
        if (bus.pixel_opaque !== (e != 0))
          $display("FAIL pixel_opaque x=%0d got %0b want %0b", x - 1, bus.pixel_opaque, e != 0);
        else n_pass++;
      end
      if (x <= x1) begin
        bus.DrawX = 10'(x);
        exp_q.push_back(model_pix(x));
      end
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) $display("FAIL %s got %0b want %0b", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus.pixel_idx !== 4'd0) $display("FAIL reset_pixel got %0d want 0", bus.pixel_idx);
    else n_pass++;
    chk_bit("reset_opaque", bus.pixel_opaque, 1'b0);
    chk_bit("reset_loaded", bus.loaded, 1'b0);
    chk_bit("reset_load_err", bus.load_err, 1'b0);
    chk_bit("reset_busy", bus.busy, 1'b0);
    rst = 1'b0;
    pulse_line(60);
  endtask

  task automatic test_basic_render();
    drive_load(100, 50, 8, 4, 0);
    chk_bit("basic_loaded", bus.loaded, 1'b1);
    set_model(100, 50, 8, 4, 0);
    pulse_line(51);
    finish_fill(8);
    pulse_line(300);
    scan(96, 110);
  endtask

  task automatic test_outside_rows();
    pulse_line(49);
    scan(95, 112);
    pulse_line(54);
    scan(95, 112);
    pulse_line(52);
    finish_fill(8);
    pulse_line(0);
    scan(98, 109);
  endtask

  task automatic test_abort();
    drive_load(20, 10, 40, 20, 3);
    set_model(20, 10, 40, 20, 3);
    pulse_line(12);
    tick();
    chk_bit("abort_busy_mid", bus.busy, 1'b1);
    tick();
    pulse_line(15);
    finish_fill(40);
    pulse_line(0);
    scan(18, 62);
  endtask

  task automatic test_load_during_fill();
    pulse_line(11);
    drive_load(200, 10, 40, 20, 3);
    chk_bit("pend_loaded", bus.loaded, 1'b1);
    chk_bit("pend_busy", bus.busy, 1'b1);
    scan(18, 30);
    finish_fill(-1);
    m_xs = 200;
    pulse_line(0);
    scan(195, 242);
  endtask

  task automatic test_load_err();
    drive_load(5, 5, 50, 30, 7);
    chk_bit("err_area", bus.load_err, 1'b1);
    chk_bit("err_loaded_kept", bus.loaded, 1'b1);
    pulse_line(13);
    finish_fill(40);
    pulse_line(0);
    scan(198, 242);
    drive_load(200, 10, 40, 20, 3);
    chk_bit("err_cleared", bus.load_err, 1'b0);
    drive_load(200, 10, 0, 20, 3);
    chk_bit("err_xdim0", bus.load_err, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    pulse_line(12);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_bit("rst_mid_loaded", bus.loaded, 1'b0);
    chk_bit("rst_mid_busy", bus.busy, 1'b0);
    n_checks++;
    if (bus.pixel_idx !== 4'd0) $display("FAIL rst_mid_pixel got %0d want 0", bus.pixel_idx);
    else n_pass++;
    m_loaded = 0; f_valid = 0; b_valid = 0; fill_on = 0;
    pulse_line(12);
    scan(18, 30);
    drive_load(20, 10, 40, 20, 3);
    chk_bit("rst_reload", bus.loaded, 1'b1);
    set_model(20, 10, 40, 20, 3);
    pulse_line(14);
    finish_fill(40);
    pulse_line(0);
    scan(18, 62);
  endtask

  initial begin
    rst            = 1'b1;
    bus.readDone   = 1'b0;
    bus.spriteData = '0;
    bus.xstart     = '0;
    bus.ystart     = '0;
    bus.xdim       = '0;
    bus.ydim       = '0;
    bus.line_start = 1'b0;
    bus.next_line  = '0;
    bus.DrawX      = '0;
    test_reset();
    test_basic_render();
    test_outside_rows();
    test_abort();
    test_load_during_fill();
    test_load_err();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sprite_row_renderer.md
# sprite_row_renderer

Downstream consumer of the SRAM sprite loader. Latches the 4500-bit sprite image and its geometry when the loader signals completion, then on every scanline pre-fetches the next line's sprite row into a ping-pong row buffer. During active video it returns the 4-bit palette index for the current DrawX. Sits between the SRAM sprite loader and the palette/colour mapper.

## Interface
- MAX_W, 64: maximum sprite width in pixels (row buffer depth)
- BPP, 4: bits per pixel in spriteData
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- readDone  in  1  one-cycle pulse from loader: spriteData/geometry valid
- spriteData  in  4500  packed sprite; pixel p = row*xdim+col occupies bits [BPP*p+BPP-1 : BPP*p]
- xstart, ystart, xdim, ydim  in  10 each  sprite screen position and size, sampled with readDone
- line_start  in  1  one-cycle pulse at start of horizontal blank
- next_line  in  10  Y of the line displayed after the *next* line_start; sampled with line_start
- DrawX  in  10  current pixel column
- pixel_idx  out  4  palette index; 0 = transparent
- pixel_opaque  out  1  pixel_idx != 0 and inside sprite
- loaded  out  1  a valid sprite is latched
- load_err  out  1  sticky; last readDone had xdim*ydim > 1125 or xdim > MAX_W or xdim/ydim = 0
- busy  out  1  FSM in FILL

## Operation
- Sprite latch: on readDone with valid geometry, copy spriteData and geometry into shadow regs, set loaded, clear load_err. Invalid geometry: keep previous sprite, set load_err.
- readDone during FILL: held in a single pending flag plus captured data; applied the cycle after FILL ends. A second readDone while pending overwrites the captured data.
- Row buffers: two MAX_W x BPP banks, front (read) and back (fill), each with a valid bit and latched Y-row.
- FSM states: IDLE (no sprite loaded) -> WAIT (loaded, waiting line_start) -> FILL -> WAIT.
- On line_start (any state except IDLE): swap front/back; compute r = next_line - ystart (11-bit signed). If loaded and 0 <= r < ydim: back.valid <= 0, col <= 0, base <= r*xdim, enter FILL. Otherwise back.valid <= 0, stay WAIT.
- FILL: one pixel per cycle: back[col] <= spriteData[BPP*(base+col) +: BPP]; after col = xdim-1, back.valid <= 1, return to WAIT.
- line_start during FILL: abort the fill (back.valid stays 0), then perform swap and new fill evaluation as above.
- Read: if front.valid and xstart <= DrawX < xstart+xdim (11-bit compare, no wrap), pixel_idx <= front[DrawX-xstart], else 0.
- Sprite extending past column 639 or line 479 is clipped by the compare. No wrap-around.

## Timing
- Reset: pixel_idx 0, pixel_opaque 0, loaded 0, load_err 0, busy 0, both banks invalid, pending 0, state IDLE.
- readDone -> loaded high next cycle (if not in FILL).
- line_start at cycle t: swap visible at t+1; busy high t+1 .. t+xdim; back.valid high at t+xdim+1.
- xdim <= 64 cycles, well within 160-pixel hblank at any Clk >= pixel clock.
- DrawX -> pixel_idx/pixel_opaque: 1 cycle registered latency. The colour stage compensates.
- Reset mid-FILL: returns to IDLE; sprite must be reloaded.

## Structure
- sprite_pkg: BPP, SPRITE_BITS = 4500, MAX_PIXELS = 1125, MAX_W, state enum {IDLE, WAIT, FILL}.
- Sub-module sprite_row_buf: the two banks, valid bits, swap, one write port, one registered read port.
- Top: latch/pending logic, FSM, address arithmetic.

## Test plan
- Load sprite xstart=100, ystart=50, xdim=8, ydim=4, pixel p = p mod 16. line_start with next_line=51, then line_start with any next_line. DrawX=100..107 -> pixel_idx 8..15 one cycle later; DrawX=99 and 108 -> 0.
- next_line=49 and 54 (outside rows 50..53) -> front invalid on that line; pixel_idx 0 across all DrawX.
- line_start pulsed 3 cycles into a xdim=40 fill -> busy stays high, restarts with new row; aborted row never displayed.
- readDone during FILL with new xstart=200 -> old geometry used until FILL ends; loaded stays 1; next line uses xstart=200.
- xdim=50, ydim=30 (1500 > 1125) -> load_err=1, previous sprite still rendered. xdim=0 -> load_err=1.
- Reset asserted mid-FILL -> next cycle loaded=0, busy=0, pixel_idx=0; line_start ignored until a new readDone.
